// File: rtl/zvc_compr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : zvc_compr_scheduler                                             |
// | Brief    : Shares one ZVCompressor128 among NUM_REQ requesters; optional   |
// |            round-robin arbitration via ZVC_SCHED_RR_EN (else fixed prio).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module zvc_compr_scheduler #(
  parameter int WORD_WIDTH     = 8,
  parameter int LINE_SIZE      = 128,
  parameter int DIST_WIDTH     = 7,
  parameter int MAX_LIFM_RSIZ  = 4,
  parameter int NUM_REQ        = 4,
  parameter int REQ_ID_WIDTH   = 2,
  parameter int COMP_LATENCY   = 3,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic [NUM_REQ-1:0]                                 req_valid,
  output logic [NUM_REQ-1:0]                                 req_ready,
  input  logic [NUM_REQ*LINE_SIZE*WORD_WIDTH-1:0]            req_lifm_line,
  input  logic [NUM_REQ*LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] req_mt_line,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]                    comp_lifm_line,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]      comp_mt_line,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]                    comp_lifm_comp,
  input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]      comp_mt_comp,
  output logic                                               rsp_valid,
  input  logic                                               rsp_ready,
  output logic [REQ_ID_WIDTH-1:0]                            rsp_id,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]                    rsp_lifm_comp,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]      rsp_mt_comp,
  input  logic                                               flush,
  output logic                                               flush_done,
  output logic                                               busy
);

  localparam int C_L  = LINE_SIZE * WORD_WIDTH;
  localparam int C_M  = LINE_SIZE * DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int C_CW = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int C_PW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int C_EW = REQ_ID_WIDTH + C_M + C_L;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_flush_done;
  logic [C_CW-1:0]         r_inflight;
  logic [C_CW-1:0]         r_count;
  logic [C_PW-1:0]         r_wr_ptr;
  logic [C_PW-1:0]         r_rd_ptr;
  logic [C_EW-1:0]         r_mem [OUT_FIFO_DEPTH];
  logic [COMP_LATENCY-1:0] r_tag_v;
  logic [REQ_ID_WIDTH-1:0] r_tag_id [COMP_LATENCY];

  logic [REQ_ID_WIDTH-1:0] w_grant_id;
  logic                    w_found;
  logic                    w_credit_ok;
  logic                    w_issue;
  logic                    w_capture;
  logic                    w_pop;
  logic [C_EW-1:0]         w_head;
  int                      w_idx;

`ifdef ZVC_SCHED_RR_EN
  logic [REQ_ID_WIDTH-1:0] r_rr_ptr;
`endif

  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ZVC_SCHED_RR_EN
      w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
`else
      w_idx = i;
`endif
      if (!w_found && req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = REQ_ID_WIDTH'(w_idx);
      end
    end
  end

  // Counts are registered, so a slot freed by a pop this cycle is only reusable next cycle.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_count}) < (C_CW + 1)'(OUT_FIFO_DEPTH);
  assign w_issue     = (r_state == ST_RUN) && w_credit_ok && w_found;
  assign req_ready   = w_issue ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_capture   = r_tag_v[COMP_LATENCY-1];
  assign rsp_valid   = (r_count != '0);
  assign w_pop       = rsp_valid && rsp_ready;
  assign w_head      = r_mem[r_rd_ptr];

  assign rsp_lifm_comp = rsp_valid ? w_head[C_L-1:0]                  : '0;
  assign rsp_mt_comp   = rsp_valid ? w_head[C_L +: C_M]               : '0;
  assign rsp_id        = rsp_valid ? w_head[C_L + C_M +: REQ_ID_WIDTH] : '0;
  assign flush_done    = r_flush_done;
  assign busy          = (r_inflight != '0) || rsp_valid || (r_state != ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      comp_lifm_line <= '0;
      comp_mt_line   <= '0;
    end else if (w_issue) begin
      comp_lifm_line <= req_lifm_line[int'(w_grant_id) * C_L +: C_L];
      comp_mt_line   <= req_mt_line[int'(w_grant_id) * C_M +: C_M];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_v <= '0;
      for (int i = 0; i < COMP_LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_grant_id;
      for (int i = 1; i < COMP_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_capture) begin
        r_mem[r_wr_ptr] <= {r_tag_id[COMP_LATENCY-1], comp_mt_comp, comp_lifm_comp};
        r_wr_ptr <= (r_wr_ptr == C_PW'(OUT_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_PW'(OUT_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ZVC_SCHED_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_grant_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (flush) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((r_inflight == '0) && (r_count == '0)) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zvc_compr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_zvc_compr_scheduler                                          |
// | Brief    : Directed + random bench with a queue-based reference model.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_zvc_compr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 3;
  localparam int DEPTH   = 4;
  localparam int WW      = 8;
  localparam int LS      = 128;
  localparam int L       = LS * WW;
  localparam int M       = LS * 7 * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_n, flush, rsp_ready;
  logic [NUM_REQ-1:0]     req_valid, req_ready;
  logic [NUM_REQ*L-1:0]   req_lifm_line;
  logic [NUM_REQ*M-1:0]   req_mt_line;
  logic [L-1:0]           comp_lifm_line, comp_lifm_comp, rsp_lifm_comp;
  logic [M-1:0]           comp_mt_line, comp_mt_comp, rsp_mt_comp;
  logic                   rsp_valid, flush_done, busy;
  logic [1:0]             rsp_id;

  zvc_compr_scheduler #(
    .WORD_WIDTH(WW), .LINE_SIZE(LS), .DIST_WIDTH(7), .MAX_LIFM_RSIZ(4),
    .NUM_REQ(NUM_REQ), .REQ_ID_WIDTH(2), .COMP_LATENCY(LAT), .OUT_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lifm_line(req_lifm_line), .req_mt_line(req_mt_line),
    .comp_lifm_line(comp_lifm_line), .comp_mt_line(comp_mt_line),
    .comp_lifm_comp(comp_lifm_comp), .comp_mt_comp(comp_mt_comp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lifm_comp(rsp_lifm_comp), .rsp_mt_comp(rsp_mt_comp),
    .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  // Zero-value compaction: nonzero words packed to the front, remainder zero.
  function automatic logic [L-1:0] zvc(input logic [L-1:0] x);
    logic [L-1:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 0; i < LS; i++) begin
      if (x[i*WW +: WW] != '0) begin
        r[k*WW +: WW] = x[i*WW +: WW];
        k++;
      end
    end
    return r;
  endfunction

  // External compressor stand-in: result appears LAT-1 registers after its input.
  logic [L-1:0] p1l, p2l;
  logic [M-1:0] p1m, p2m;
  always @(posedge clk) begin
    p1l <= zvc(comp_lifm_line);
    p1m <= ~comp_mt_line;
    p2l <= p1l;
    p2m <= p1m;
  end
  assign comp_lifm_comp = p2l;
  assign comp_mt_comp   = p2m;

  typedef struct {
    int           id;
    logic [L-1:0] lifm;
    logic [M-1:0] mt;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  int           ncyc = 0;
  int           phase = 0;
  int           rr_ptr = 0;
  int           acc_id, n_rsp, n_acc;
  logic         popped, fd_now;
  logic [L-1:0] last_l;
  logic [M-1:0] last_m;

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic rnd_lines();
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int w = 0; w < LS; w++)
        req_lifm_line[r*L + w*WW +: WW] = ($urandom % 2 == 0) ? WW'($urandom) : '0;
      for (int b = 0; b < M / 32; b++)
        req_mt_line[r*M + b*32 +: 32] = $urandom;
    end
  endtask

  task automatic model_reset();
    q.delete();
    phase  = 0;
    rr_ptr = 0;
    last_l = '0;
    last_m = '0;
  endtask

  // One cycle: check outputs against the model mid-cycle, account the upcoming edge, advance.
  task automatic cyc();
    logic [NUM_REQ-1:0] er;
    int   win, j, sz0, nphase;
    exp_t e;
    #4;
    sz0 = q.size();
    er  = '0;
    win = -1;
    j   = 0;
    if (phase == 0 && sz0 < DEPTH) begin
      for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ZVC_SCHED_RR_EN
        j = (rr_ptr + i) % NUM_REQ;
`else
        j = i;
`endif
        if (win < 0 && req_valid[j]) win = j;
      end
      if (win >= 0) er[win] = 1'b1;
    end
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, (sz0 > 0) && (q[0].acc + LAT <= ncyc));
    chk("flush_done", flush_done, phase == 2);
    chk("busy", busy, (sz0 != 0) || (phase != 0));
    chk("comp_lifm_line", comp_lifm_line, last_l);
    chk("comp_mt_line", comp_mt_line, last_m);
    fd_now = flush_done;
    nphase = phase;
    if (phase == 0 && flush) nphase = 1;
    else if (phase == 1 && sz0 == 0) nphase = 2;
    else if (phase == 2) nphase = 0;
    popped = 1'b0;
    if (rsp_valid && rsp_ready && sz0 > 0) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_lifm_comp", rsp_lifm_comp, q[0].lifm);
      chk("rsp_mt_comp", rsp_mt_comp, q[0].mt);
      void'(q.pop_front());
      n_rsp++;
      popped = 1'b1;
    end
    acc_id = -1;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i]) acc_id = i;
    if (acc_id >= 0) begin
      e.id   = acc_id;
      e.lifm = zvc(req_lifm_line[acc_id*L +: L]);
      e.mt   = ~req_mt_line[acc_id*M +: M];
      e.acc  = ncyc + 1;
      q.push_back(e);
      last_l = req_lifm_line[acc_id*L +: L];
      last_m = req_mt_line[acc_id*M +: M];
      rr_ptr = (acc_id + 1) % NUM_REQ;
      n_acc++;
    end
    @(posedge clk);
    ncyc++;
    #1;
    phase = nphase;
  endtask

  initial begin
    int grants[$];
    int exp_g, cnt, r0, fd_idx, done_cnt, acc_before, rsp_at, resume;
    n_rsp = 0; n_acc = 0; acc_id = -1;
    reset_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0; req_valid = '0;
    req_lifm_line = '0; req_mt_line = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_comp_lifm", comp_lifm_line, '0);
    chk("rst_comp_mt", comp_mt_line, '0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_rsp_lifm", rsp_lifm_comp, '0);
    chk("rst_rsp_mt", rsp_mt_comp, '0);
    reset_n = 1'b1;

    // Arbitration order with all requesters valid
    rnd_lines();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    repeat (12) begin
      cyc();
      if (acc_id >= 0) grants.push_back(acc_id);
    end
    for (int i = 0; i < 5; i++) begin
`ifdef ZVC_SCHED_RR_EN
      exp_g = i % NUM_REQ;
`else
      exp_g = 0;
`endif
      chk("grant_order", grants[i], exp_g);
    end
    req_valid = '0;
    repeat (8) cyc();

    // Single line from requester 2
    req_lifm_line = '0; req_mt_line = '0;
    req_lifm_line[2*L + 3*WW +: WW]  = 8'd13;
    req_lifm_line[2*L + 8*WW +: WW]  = 8'd47;
    req_lifm_line[2*L + 15*WW +: WW] = 8'd22;
    req_mt_line[2*M + 3*28 +: 7]  = 7'd1;
    req_mt_line[2*M + 8*28 +: 7]  = 7'd1;
    req_mt_line[2*M + 15*28 +: 7] = 7'd1;
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    cyc(); cyc();
    chk("t1_rsp_early", rsp_valid, 1'b0);
    cyc();
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_id", rsp_id, 2'd2);
    chk("t1_words", rsp_lifm_comp[23:0], {8'd22, 8'd47, 8'd13});
    repeat (4) cyc();

    // Backpressure: output stalled
    rnd_lines();
    rsp_ready = 1'b0; req_valid = 4'b0010;
    cnt = 0;
    repeat (10) begin
      cyc();
      if (acc_id >= 0) cnt++;
    end
    chk("bp_accepts", cnt, 4);
    chk("bp_ready_low", req_ready, '0);
    rsp_ready = 1'b1;
    cyc();
    chk("bp_pop", popped, 1'b1);
    chk("bp_no_same_cycle_accept", acc_id, -1);
    rsp_ready = 1'b0;
    cyc();
    chk("bp_late_accept", acc_id, 1);
    rsp_ready = 1'b1; req_valid = '0;
    repeat (12) cyc();

    // Flush with 3 lines in flight
    r0 = n_rsp;
    req_valid = 4'b0001;
    repeat (3) cyc();
    req_valid = '0; flush = 1'b1;
    cyc();
    flush = 1'b0; req_valid = 4'b1111;
    fd_idx = -1; done_cnt = 0; acc_before = 0; rsp_at = -1; resume = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (fd_now) begin
        done_cnt++;
        if (fd_idx < 0) begin
          fd_idx = i;
          rsp_at = n_rsp - r0;
        end
      end
      if (fd_idx < 0 && acc_id >= 0) acc_before++;
      if (fd_idx >= 0 && i == fd_idx + 1 && acc_id >= 0) resume = 1;
    end
    chk("fl_done_once", done_cnt, 1);
    chk("fl_no_accepts", acc_before, 0);
    chk("fl_rsp_count", rsp_at, 3);
    chk("fl_resume", resume, 1);
    req_valid = '0;
    repeat (10) cyc();

    // Request accepted on the same edge flush is sampled
    r0 = n_rsp;
    req_valid = 4'b0001; flush = 1'b1;
    cyc();
    chk("sf_accept", acc_id, 0);
    req_valid = '0; flush = 1'b0;
    fd_idx = -1; rsp_at = -1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (fd_now && fd_idx < 0) begin
        fd_idx = i;
        rsp_at = n_rsp - r0;
      end
    end
    chk("sf_rsp_before_done", rsp_at, 1);

    // Asynchronous reset with lines buffered
    rsp_ready = 1'b0; req_valid = 4'b0001;
    repeat (2) cyc();
    req_valid = '0;
    repeat (3) cyc();
    chk("rm_rsp_before_reset", rsp_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_rsp_valid_now", rsp_valid, 1'b0);
    chk("rm_busy_now", busy, 1'b0);
    model_reset();
    @(posedge clk);
    ncyc++;
    #1;
    reset_n = 1'b1; rsp_ready = 1'b1;
    repeat (8) cyc();
    chk("rm_busy_after", busy, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      rnd_lines();
      req_valid = NUM_REQ'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 50) == 0;
      cyc();
    end
    flush = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (20) cyc();
    chk("end_model_empty", q.size(), 0);
    chk("end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
